branch_redirect_ctrl: RTL

Sequencing controller for the EX-stage branch resolution path. It takes the breq/brlt comparison flags for the instruction in EX and decides taken/not-taken for conditional branches, JAL and JALR. It then runs the PC redirect handshake with fetch and holds flush to the younger pipeline stages for a fixed number of cycles. It also keeps saturating branch/taken statistics counters. Static predict-not-taken: every taken transfer is a redirect.

---
 rtl/branch_redirect_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - EX-stage branch resolution, PC redirect handshake and flush sequencer
module branch_redirect_ctrl #(
  parameter int AWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic                 stall_i,
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic                 breq_i,
  input  logic                 brlt_i,
  input  logic [AWIDTH-1:0]    target_i,
  input  logic                 redirect_ready_i,
  output logic                 redirect_valid_o,
  output logic [AWIDTH-1:0]    redirect_pc_o,
  output logic                 flush_o,
  output logic                 busy_o,
  output logic                 taken_o,
  output logic                 misaligned_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] branch_count_o,
  output logic [CNT_WIDTH-1:0] taken_count_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Flush counter must hold FLUSH_CYCLES itself.
  localparam int FCW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [AWIDTH-1:0]     redirect_pc_q, redirect_pc_d;
  logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;
  logic                  taken_q, taken_d;
  logic                  misaligned_q, misaligned_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]  taken_cnt_q, taken_cnt_d;

  logic                  is_branch;
  logic                  is_jal;
  logic                  is_jalr;
  logic                  is_xfer;
  logic                  illegal_f3;
  logic                  cond_taken;
  logic                  xfer_taken;
  logic                  accept;
  logic [AWIDTH-1:0]     final_tgt;
  logic                  tgt_misaligned;

  // Decode the EX instruction and resolve direction and target.
  always_comb begin
    is_branch  = (opcode_i == OP_BRANCH);
    is_jal     = (opcode_i == OP_JAL);
    is_jalr    = (opcode_i == OP_JALR);
    is_xfer    = is_branch | is_jal | is_jalr;
    illegal_f3 = is_branch & (funct3_i[2:1] == 2'b01);
    cond_taken = 1'b0;
    case (funct3_i)
      3'b000:  cond_taken = breq_i;
      3'b001:  cond_taken = ~breq_i;
      3'b100:  cond_taken = brlt_i;
      3'b101:  cond_taken = ~brlt_i;
      3'b110:  cond_taken = brlt_i;
      3'b111:  cond_taken = ~brlt_i;
      default: cond_taken = 1'b0;
    endcase
    xfer_taken     = is_jal | is_jalr | (is_branch & cond_taken);
    final_tgt      = is_jalr ? {target_i[AWIDTH-1:1], 1'b0} : target_i;
    tgt_misaligned = final_tgt[1];
    // Wrong-path instructions behind a redirect are never accepted.
    accept         = (state_q == S_IDLE) & valid_i & ~stall_i & is_xfer;
  end

  // Next-state logic for the redirect/flush sequencer and result pulses.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    flush_cnt_d   = flush_cnt_q;
    taken_d       = 1'b0;
    misaligned_d  = 1'b0;
    illegal_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          taken_d      = xfer_taken;
          misaligned_d = xfer_taken & tgt_misaligned;
          illegal_d    = illegal_f3;
          if (xfer_taken && !tgt_misaligned) begin
            state_d       = S_REDIRECT;
            redirect_pc_d = final_tgt;
          end
        end
      end
      S_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d     = S_FLUSH;
          flush_cnt_d = FCW'(FLUSH_CYCLES);
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q <= FCW'(1)) begin
          state_d     = S_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FCW'(1);
        end
      end
      default: begin
        state_d     = S_IDLE;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Saturating statistics counters.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (accept && !(&branch_cnt_q)) begin
      branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
    end
    if (accept && xfer_taken && !(&taken_cnt_q)) begin
      taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State and output registers; reset aborts any redirect in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      redirect_pc_q <= '0;
      flush_cnt_q   <= '0;
      taken_q       <= 1'b0;
      misaligned_q  <= 1'b0;
      illegal_q     <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      flush_cnt_q   <= flush_cnt_d;
      taken_q       <= taken_d;
      misaligned_q  <= misaligned_d;
      illegal_q     <= illegal_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign redirect_valid_o = (state_q == S_REDIRECT);
  assign redirect_pc_o    = redirect_pc_q;
  assign flush_o          = (state_q != S_IDLE);
  assign busy_o           = (state_q != S_IDLE);
  assign taken_o          = taken_q;
  assign misaligned_o     = misaligned_q;
  assign illegal_o        = illegal_q;
  assign branch_count_o   = branch_cnt_q;
  assign taken_count_o    = taken_cnt_q;

endmodule
